// File: rtl/atomic_cnt_pkg.sv
// Shared helpers, response type and configuration checks for atomic_counter_bank.
package atomic_cnt_pkg;

  // Widest read bus the response struct can carry.
  localparam int RSP_DATA_W = 64;

  typedef struct packed {
    logic                  ack;
    logic                  err;
    logic [RSP_DATA_W-1:0] data;
  } rsp_t;

  function automatic int nwords(input int cnt_w, input int bus_w);
    return cnt_w / bus_w;
  endfunction

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit cfg_ok(input int num_ch, input int cnt_w, input int bus_w);
    return (num_ch >= 1) && (bus_w >= 1) && (bus_w <= RSP_DATA_W) &&
           (cnt_w >= bus_w) && ((cnt_w % bus_w) == 0);
  endfunction

endpackage

// File: rtl/atomic_cnt_channel.sv
// One free-running event counter; clr overrides the increment at the same edge.
module atomic_cnt_channel #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trig,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt_q,
  output logic [CNT_W-1:0] cnt_next
);

  assign cnt_next = cnt_q + CNT_W'(trig);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    cnt_q <= '0;
    else if (clr) cnt_q <= '0;
    else          cnt_q <= cnt_next;
  end

endmodule

// File: rtl/atomic_counter_bank.sv
// Bank of event counters read one BUS_W word at a time; word 0 snapshots the upper words.
// Optional clear-on-read behaviour is enabled by defining ATOMIC_CNT_CLR_ON_READ_EN.
module atomic_counter_bank
  import atomic_cnt_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 64,
  parameter int BUS_W  = 32,
  localparam int NW    = nwords(CNT_W, BUS_W),
  localparam int CH_W  = idx_w(NUM_CH),
  localparam int WD_W  = idx_w(NW)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] trig_i,
  input  logic              req_i,
  input  logic [CH_W-1:0]   ch_i,
  input  logic [WD_W-1:0]   word_i,
  output logic              ack_o,
  output logic [BUS_W-1:0]  rdata_o,
  output logic              err_o
);

`ifdef ATOMIC_CNT_CLR_ON_READ_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  localparam bit CFG_OK = cfg_ok(NUM_CH, CNT_W, BUS_W);

  if (!CFG_OK) begin : g_bad_cfg
    $error("atomic_counter_bank: CNT_W must be a multiple of BUS_W and NUM_CH >= 1");
  end

  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_next;
  logic [NUM_CH-1:0]            clr;
  logic [CNT_W-1:0]             sel_next;
  logic                         ch_ok, wd_ok, is_w0, take;
  logic                         snap_hit;
  logic [BUS_W-1:0]             snap_word;
  rsp_t                         rsp_d, rsp_q;

  assign ch_ok    = 32'(ch_i) < NUM_CH;
  assign wd_ok    = 32'(word_i) < NW;
  assign is_w0    = (word_i == '0);
  assign take     = req_i & ch_ok & is_w0;
  assign sel_next = ch_ok ? cnt_next[ch_i] : '0;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign clr[c] = CLR_EN & take & (32'(ch_i) == c);
    atomic_cnt_channel #(.CNT_W(CNT_W)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .trig     (trig_i[c]),
      .clr      (clr[c]),
      .cnt_q    (cnt_q[c]),
      .cnt_next (cnt_next[c])
    );
  end

  if (NW > 1) begin : g_snap
    logic [NW-2:0][BUS_W-1:0] snap_q;
    logic [CH_W-1:0]          snap_ch;
    logic                     snap_valid;

    // Captures cnt_next so the upper words match the word 0 that is being returned.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        snap_q     <= '0;
        snap_ch    <= '0;
        snap_valid <= 1'b0;
      end else if (take) begin
        snap_q     <= sel_next[CNT_W-1:BUS_W];
        snap_ch    <= ch_i;
        snap_valid <= 1'b1;
      end
    end

    assign snap_hit = snap_valid & (snap_ch == ch_i);

    always_comb begin
      snap_word = '0;
      for (int k = 1; k < NW; k++)
        if (32'(word_i) == k) snap_word = snap_q[k-1];
    end
  end else begin : g_nosnap
    assign snap_hit  = 1'b0;
    assign snap_word = '0;
  end

  always_comb begin
    rsp_d     = '0;
    rsp_d.ack = req_i;
    if (req_i) begin
      if (!ch_ok || !wd_ok) rsp_d.err = 1'b1;
      else if (is_w0)       rsp_d.data[BUS_W-1:0] = sel_next[BUS_W-1:0];
      else if (snap_hit)    rsp_d.data[BUS_W-1:0] = snap_word;
      else                  rsp_d.err = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rsp_q <= '0;
    else       rsp_q <= rsp_d;
  end

  assign ack_o   = rsp_q.ack;
  assign err_o   = rsp_q.err;
  assign rdata_o = rsp_q.data[BUS_W-1:0];

  logic unused_sink;
  assign unused_sink = ^{rsp_q, cnt_q};

endmodule

// File: tb/tb_atomic_counter_bank.sv
// Randomized and directed checks of atomic_counter_bank against a behavioural counter model.
module tb_atomic_counter_bank;

  localparam int NUM_CH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  trig_i;
  logic        req_i;
  logic [1:0]  ch_i;
  logic        word_i;
  logic        ack_o, err_o;
  logic [31:0] rdata_o;

  logic        req5;
  logic [2:0]  ch5;
  logic        word5;
  logic        ack5, err5;
  logic [31:0] rdata5;

  always #5 clk = ~clk;

  atomic_counter_bank #(.NUM_CH(4), .CNT_W(64), .BUS_W(32)) dut (
    .clk(clk), .reset(reset), .trig_i(trig_i), .req_i(req_i), .ch_i(ch_i),
    .word_i(word_i), .ack_o(ack_o), .rdata_o(rdata_o), .err_o(err_o)
  );

  atomic_counter_bank #(.NUM_CH(5), .CNT_W(64), .BUS_W(32)) dut5 (
    .clk(clk), .reset(reset), .trig_i(5'b0), .req_i(req5), .ch_i(ch5),
    .word_i(word5), .ack_o(ack5), .rdata_o(rdata5), .err_o(err5)
  );

  // Reference model: plain counts plus the last word-0 snapshot.
  longint unsigned m_cnt [NUM_CH];
  longint unsigned m_snap;
  int              m_snap_ch;
  bit              m_snap_v;
  bit              clr_on_read;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) m_cnt[c] = 0;
    m_snap = 0; m_snap_ch = 0; m_snap_v = 0;
  endtask

  // Drive one cycle on the main DUT, advance the model, check the response.
  task automatic cycle(input string tag, input logic [3:0] trig, input bit req,
                       input int ch, input int wd);
    longint unsigned nxt [NUM_CH];
    bit              e_err;
    longint unsigned e_data;
    trig_i = trig; req_i = req; ch_i = 2'(ch); word_i = wd[0];
    for (int c = 0; c < NUM_CH; c++) nxt[c] = m_cnt[c] + longint'(trig[c]);
    e_err = 0; e_data = 0;
    if (req) begin
      if (wd == 0) begin
        e_data    = nxt[ch] & 64'hFFFF_FFFF;
        m_snap    = nxt[ch];
        m_snap_ch = ch;
        m_snap_v  = 1;
        if (clr_on_read) nxt[ch] = 0;
      end else if (m_snap_v && m_snap_ch == ch) begin
        e_data = m_snap >> 32;
      end else begin
        e_err = 1;
      end
    end
    @(posedge clk);
    for (int c = 0; c < NUM_CH; c++) m_cnt[c] = nxt[c];
    @(negedge clk);
    chk({tag, ".ack"},   ack_o,   req);
    chk({tag, ".err"},   err_o,   e_err);
    chk({tag, ".rdata"}, rdata_o, e_data);
  endtask

  task automatic force_cnt(input int ch, input longint unsigned v);
    case (ch)
      0: force dut.g_ch[0].u_ch.cnt_q = v;
      1: force dut.g_ch[1].u_ch.cnt_q = v;
      2: force dut.g_ch[2].u_ch.cnt_q = v;
      default: force dut.g_ch[3].u_ch.cnt_q = v;
    endcase
    #1;
    case (ch)
      0: release dut.g_ch[0].u_ch.cnt_q;
      1: release dut.g_ch[1].u_ch.cnt_q;
      2: release dut.g_ch[2].u_ch.cnt_q;
      default: release dut.g_ch[3].u_ch.cnt_q;
    endcase
    m_cnt[ch] = v;
  endtask

  task automatic cycle5(input string tag, input int ch, input int wd,
                        input bit e_err, input logic [31:0] e_data);
    req5 = 1; ch5 = 3'(ch); word5 = wd[0];
    @(posedge clk); @(negedge clk);
    req5 = 0;
    chk({tag, ".ack"},   ack5,   1'b1);
    chk({tag, ".err"},   err5,   e_err);
    chk({tag, ".rdata"}, rdata5, e_data);
  endtask

  initial begin
`ifdef ATOMIC_CNT_CLR_ON_READ_EN
    clr_on_read = 1;
`else
    clr_on_read = 0;
`endif
    reset = 1; trig_i = 0; req_i = 0; ch_i = 0; word_i = 0;
    req5 = 0; ch5 = 0; word5 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 0;

    // 1. reset with traffic active: pending ack dropped, snapshot invalidated
    cycle("pre", 4'hF, 1, 0, 0);
    trig_i = 4'hF; req_i = 1; ch_i = 1; word_i = 0;
    @(posedge clk); #2;
    reset = 1; #1;
    chk("rst.ack", ack_o, 1'b0);
    chk("rst.err", err_o, 1'b0);
    chk("rst.rdata", rdata_o, 32'd0);
    req_i = 0; trig_i = 0;
    @(negedge clk); reset = 0;
    model_reset();
    cycle("rst.w1", 4'h0, 1, 0, 1);

    // 2. five triggers on ch2 then a word-0 read
    repeat (5) cycle("cnt", 4'b0100, 0, 0, 0);
    cycle("t2", 4'h0, 1, 2, 0);
    chk("t2.lit", rdata_o, 32'd5);

    // 3. atomicity across the low-word carry
    force_cnt(1, 64'h0000_0000_FFFF_FFFE);
    cycle("t3.w0", 4'b0010, 1, 1, 0);
    chk("t3.lit", rdata_o, 32'hFFFF_FFFF);
    repeat (3) cycle("t3.run", 4'b0010, 0, 0, 0);
    cycle("t3.w1", 4'b0010, 1, 1, 1);
    chk("t3.snap", rdata_o, 32'd0);

    // 4. snapshot owned by another channel
    cycle("t4.w0", 4'h0, 1, 2, 0);
    cycle("t4.w1", 4'h0, 1, 1, 1);
    cycle5("t4.ch4", 4, 0, 0, 32'd0);
    cycle5("t4.ch5", 5, 0, 1, 32'd0);
    cycle5("t4.ch4w1", 4, 1, 0, 32'd0);
    cycle5("t4.ch7w1", 7, 1, 1, 32'd0);

    // 5. wrap through all ones, then back-to-back reads
    force_cnt(0, 64'hFFFF_FFFF_FFFF_FFFF);
    cycle("t5.trig", 4'b0001, 0, 0, 0);
    cycle("t5.w0", 4'h0, 1, 0, 0);
    cycle("t5.w1", 4'h0, 1, 0, 1);
    chk("t5.lit", rdata_o, 32'd0);
    for (int c = 0; c < NUM_CH; c++) cycle("t5.b2b", 4'($urandom), 1, c, 0);

    // 6. clear-on-read semantics (expectation depends on the build)
    force_cnt(3, 64'd9);
    cycle("t6.r1", 4'b1000, 1, 3, 0);
    chk("t6.lit", rdata_o, 32'd10);
    cycle("t6.r2", 4'h0, 1, 3, 0);
    chk("t6.lit2", rdata_o, clr_on_read ? 32'd0 : 32'd10);

    // randomized traffic, including upper-word carries
    force_cnt(2, 64'h0000_0001_FFFF_FFF0);
    for (int i = 0; i < 300; i++)
      cycle("rnd", 4'($urandom), ($urandom_range(0, 3) != 0), $urandom_range(0, 3),
            $urandom_range(0, 1));
    cycle("end", 4'h0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
